// File: rtl/chunked_addsub.sv
// Multi-cycle adder/subtractor: processes CHUNK bits per clock, LSB chunk first.
// Subtraction is performed as a + ~b + 1 through the same chunk adder.
module chunked_addsub #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             overflow
);

  localparam int N   = WIDTH / CHUNK;
  localparam int IW  = (N > 1) ? $clog2(N) : 1;
  localparam int BW  = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam int MSB = WIDTH - 1;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [IW-1:0]    idx_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;
  logic [WIDTH-1:0] sum_q;
  logic             c_out_q;
  logic             ovf_q;

  logic [BW-1:0]    base;
  logic [CHUNK:0]   chunk_sum;
  logic             accept;

  always_comb begin
    base      = BW'(int'(idx_q) * CHUNK);
    chunk_sum = {1'b0, a_q[base +: CHUNK]} + {1'b0, b_q[base +: CHUNK]}
              + (CHUNK+1)'(carry_q);
    accept    = start && (state_q != RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      idx_q   <= '0;
      carry_q <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else if (accept) begin
      state_q <= RUN;
      idx_q   <= '0;
      a_q     <= a;
      b_q     <= sub ? ~b : b;
      carry_q <= sub ? 1'b1 : c_in;
      sum_q   <= '0;
      c_out_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      case (state_q)
        RUN: begin
          sum_q[base +: CHUNK] <= chunk_sum[CHUNK-1:0];
          carry_q              <= chunk_sum[CHUNK];
          idx_q                <= idx_q + IW'(1);
          // Last chunk: its top bit is the final sum MSB used for overflow.
          if (idx_q == IW'(N - 1)) begin
            state_q <= DONE;
            c_out_q <= chunk_sum[CHUNK];
            ovf_q   <= (a_q[MSB] == b_q[MSB]) && (chunk_sum[CHUNK-1] != a_q[MSB]);
          end
        end
        DONE:    state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy     = (state_q == RUN);
  assign done     = (state_q == DONE);
  assign sum      = sum_q;
  assign c_out    = c_out_q;
  assign overflow = ovf_q;

endmodule

// File: tb/tb_chunked_addsub.sv
// Bench for chunked_addsub: directed cases plus random operands on four
// parameterisations, checked against an arithmetic reference model.
module tb_chunked_addsub;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int unsigned n_cmp = 0;
  int unsigned n_bad = 0;

  logic [3:0]       st, sb, ci;
  logic [3:0][31:0] av, bv;
  logic [3:0]       bz, dn, co, ov;
  logic [31:0]      s0, s1, s2;
  logic [7:0]       s3;

  int NK [4] = '{4, 1, 32, 2};
  int WK [4] = '{32, 32, 32, 8};

  chunked_addsub #(.WIDTH(32), .CHUNK(8)) u0 (
    .clk(clk), .rst_n(rst_n), .start(st[0]), .sub(sb[0]), .a(av[0]), .b(bv[0]),
    .c_in(ci[0]), .busy(bz[0]), .done(dn[0]), .sum(s0), .c_out(co[0]), .overflow(ov[0]));
  chunked_addsub #(.WIDTH(32), .CHUNK(32)) u1 (
    .clk(clk), .rst_n(rst_n), .start(st[1]), .sub(sb[1]), .a(av[1]), .b(bv[1]),
    .c_in(ci[1]), .busy(bz[1]), .done(dn[1]), .sum(s1), .c_out(co[1]), .overflow(ov[1]));
  chunked_addsub #(.WIDTH(32), .CHUNK(1)) u2 (
    .clk(clk), .rst_n(rst_n), .start(st[2]), .sub(sb[2]), .a(av[2]), .b(bv[2]),
    .c_in(ci[2]), .busy(bz[2]), .done(dn[2]), .sum(s2), .c_out(co[2]), .overflow(ov[2]));
  chunked_addsub #(.WIDTH(8), .CHUNK(4)) u3 (
    .clk(clk), .rst_n(rst_n), .start(st[3]), .sub(sb[3]), .a(av[3][7:0]), .b(bv[3][7:0]),
    .c_in(ci[3]), .busy(bz[3]), .done(dn[3]), .sum(s3), .c_out(co[3]), .overflow(ov[3]));

  // {c_out, sum} = a + b' + cin' at w bits; carry lands in bit w.
  function automatic logic [32:0] model_sum(int w, logic s, logic [31:0] x, logic [31:0] y, logic c);
    logic [32:0] m;
    logic [31:0] yy;
    m  = (33'd1 << w) - 33'd1;
    yy = s ? ~y : y;
    return ({1'b0, x} & m) + ({1'b0, yy} & m) + 33'(s ? 1'b1 : c);
  endfunction

  // Signed overflow: the exact signed result falls outside the w-bit range.
  function automatic logic model_ovf(int w, logic s, logic [31:0] x, logic [31:0] y, logic c);
    longint m, sx, sy, r;
    m  = (longint'(1) << w) - 1;
    sx = longint'(x) & m;
    sy = longint'(y) & m;
    if (x[w-1]) sx = sx - (longint'(1) << w);
    if (y[w-1]) sy = sy - (longint'(1) << w);
    r  = s ? (sx - sy) : (sx + sy + longint'(c));
    return (r > ((longint'(1) << (w-1)) - 1)) || (r < -(longint'(1) << (w-1)));
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h", nm, act, exp);
    end
  endtask

  // Cycle model for u0: RUN with k chunks done, DONE, or idle holding last result.
  logic        m_run, m_done;
  int unsigned m_k;
  logic [32:0] m_pend, m_fin;
  logic        m_pov, m_fov;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_run <= 1'b0; m_done <= 1'b0; m_k <= 0;
      m_pend <= '0; m_fin <= '0; m_pov <= 1'b0; m_fov <= 1'b0;
    end else if (!m_run && st[0]) begin
      m_run  <= 1'b1; m_done <= 1'b0; m_k <= 0;
      m_pend <= model_sum(32, sb[0], av[0], bv[0], ci[0]);
      m_pov  <= model_ovf(32, sb[0], av[0], bv[0], ci[0]);
    end else if (m_run) begin
      m_k <= m_k + 1;
      if (m_k + 1 == 4) begin
        m_run <= 1'b0; m_done <= 1'b1;
      end
    end else if (m_done) begin
      m_done <= 1'b0; m_fin <= m_pend; m_fov <= m_pov;
    end
  end

  logic [31:0] e_sum;
  logic        e_co, e_ov;
  always @(negedge clk) begin
    if (rst_n) begin
      if (m_run) begin
        e_sum = m_pend[31:0] & 32'((64'd1 << (8 * m_k)) - 64'd1);
        e_co  = 1'b0; e_ov = 1'b0;
      end else if (m_done) begin
        e_sum = m_pend[31:0]; e_co = m_pend[32]; e_ov = m_pov;
      end else begin
        e_sum = m_fin[31:0]; e_co = m_fin[32]; e_ov = m_fov;
      end
      chk("u0_cycle", {bz[0], dn[0], co[0], ov[0], s0}, {m_run, m_done, e_co, e_ov, e_sum});
    end
  end

  function automatic logic [33:0] act_res(int k);
    case (k)
      0:       return {ov[0], co[0], s0};
      1:       return {ov[1], co[1], s1};
      2:       return {ov[2], co[2], s2};
      default: return {ov[3], 24'd0, co[3], s3};
    endcase
  endfunction

  task automatic launch(int k, logic s, logic [31:0] x, logic [31:0] y, logic c);
    @(negedge clk);
    st[k] = 1'b1; sb[k] = s; av[k] = x; bv[k] = y; ci[k] = c;
    @(negedge clk);
    st[k] = 1'b0;
  endtask

  // lat counts rising edges after the start-sampling edge until done is seen.
  task automatic wait_done(int k, int lat0, output int lat);
    lat = lat0;
    while (!dn[k] && lat < 200) begin
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic check_res(string nm, int k, int lat, logic e_ovf, logic [32:0] e_res);
    chk({nm, "_latency"}, 64'(lat), 64'(NK[k]));
    chk(nm, 64'(act_res(k)), 64'({e_ovf, e_res}));
  endtask

  int          lat;
  logic        rs, rc;
  logic [31:0] rx, ry;

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1);
  end

  initial begin
    st = '0; sb = '0; ci = '0; av = '0; bv = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("reset_state", {bz, dn, co, ov, s0}, 64'd0);

    launch(0, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1);
    wait_done(0, 0, lat);
    check_res("all_ones_add", 0, lat, 1'b0, 33'h1_FFFF_FFFF);

    launch(0, 1'b1, 32'd5, 32'd7, 1'b0);
    wait_done(0, 0, lat);
    check_res("sub_5_7", 0, lat, 1'b0, 33'h0_FFFF_FFFE);

    launch(0, 1'b1, 32'd7, 32'd5, 1'b0);
    wait_done(0, 0, lat);
    check_res("sub_7_5", 0, lat, 1'b0, 33'h1_0000_0002);

    // Carry ripple across chunk boundary, with a start pulse during RUN.
    launch(0, 1'b0, 32'h0000_FFFF, 32'h0, 1'b1);
    @(negedge clk);
    st[0] = 1'b1; sb[0] = 1'b1; av[0] = 32'h1234_5678; bv[0] = 32'h1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, 2, lat);
    check_res("chunk_carry", 0, lat, 1'b0, 33'h0_0001_0000);

    // Back-to-back: start held while in DONE.
    st[0] = 1'b1; sb[0] = 1'b0; av[0] = 32'h7FFF_FFFF; bv[0] = 32'h1; ci[0] = 1'b0;
    @(negedge clk);
    st[0] = 1'b0;
    chk("b2b_busy", 64'(bz[0]), 64'd1);
    wait_done(0, 0, lat);
    check_res("add_ovf", 0, lat, 1'b1, 33'h0_8000_0000);

    st[0] = 1'b1; sb[0] = 1'b1; av[0] = 32'h8000_0000; bv[0] = 32'h1;
    @(negedge clk);
    st[0] = 1'b0;
    wait_done(0, 0, lat);
    check_res("sub_ovf", 0, lat, 1'b1, 33'h1_7FFF_FFFF);

    // Asynchronous reset in the middle of RUN.
    launch(0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 chk("async_reset", {bz[0], dn[0], co[0], ov[0], s0}, 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("no_done_after_abort", 64'(dn[0]), 64'd0);
    launch(0, 1'b0, 32'h1234_5678, 32'h1111_1111, 1'b0);
    wait_done(0, 0, lat);
    check_res("after_reset", 0, lat, 1'b0, 33'h0_2345_6789);

    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < 1000; i++) begin
        rs = 1'($urandom_range(0, 1));
        rc = 1'($urandom_range(0, 1));
        rx = $urandom;
        ry = $urandom;
        case ($urandom_range(0, 7))
          0: rx = '1;
          1: ry = '1;
          2: rx = '0;
          3: ry = rx;
          default: ;
        endcase
        launch(k, rs, rx, ry, rc);
        wait_done(k, 0, lat);
        check_res("random", k, lat, model_ovf(WK[k], rs, rx, ry, rc),
                  model_sum(WK[k], rs, rx, ry, rc));
      end
    end

    repeat (2) @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
